audio_feed_key_master: RTL

- Avalon-MM initiator that services the 4-bit key PIO (edge-capturing input peripheral) in hardware, so no soft CPU is needed to handle key presses.
- On PIO irq: reads the edge-capture register, clears it, and emits one key-event word on a valid/ready stream to the audio control logic.
- Programs the PIO interrupt mask once after reset.
- Applies a holdoff after each event so contact bounce is not reported again.

---
 rtl/audio_feed_key_master.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/audio_feed_key_master.sv
// audio_feed_key_master
//   Avalon-MM initiator that services a 4-bit edge-capturing key PIO in
//   hardware. It programs the PIO interrupt mask once after reset. On each
//   irq it reads the edge-capture register (address 3) and clears it. It
//   then offers one key-event word on a valid/ready stream, and waits out a
//   holdoff period so contact bounce is not reported again.
//
//   Optional build macro: AUDIO_FEED_KEY_LEVEL_READ_EN
//     defined   -> the raw key levels (PIO address 0) are read after the
//                  edge register and reported on event_level.
//     undefined -> event_level is tied to zero; address 0 is never accessed.
//
// Ports
//   clk, reset_n     system clock, synchronous active-low reset
//   irq              PIO interrupt (edge_capture & mask non-zero)
//   avm_address      PIO register select
//   avm_chipselect   PIO select
//   avm_write_n      active-low write strobe
//   avm_writedata    write data
//   avm_readdata     PIO read data (valid READ_LATENCY cycles after address)
//   event_valid      key event available
//   event_ready      consumer accepts event
//   event_keys       captured edge bits (1 = key pressed)
//   event_level      raw key levels (zero unless level read is enabled)
//   init_done        mask programmed, servicing active

module audio_feed_key_master #(
  parameter int unsigned KEY_WIDTH      = 4,
  parameter logic [3:0]  IRQ_MASK       = 4'hF,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned HOLDOFF_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 irq,
  output logic [1:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [KEY_WIDTH-1:0] event_keys,
  output logic [KEY_WIDTH-1:0] event_level,
  output logic                 init_done
);

  typedef enum logic [3:0] {
    S_BOOT,
    S_INIT,
    S_IDLE,
    S_RD_EC,
    S_RD_WAIT,
    S_RD_LVL,
    S_RD_LVL_WAIT,
    S_CLR,
    S_PUSH,
    S_HOLD
  } state_t;

  localparam logic [31:0] RD_LAST   = 32'(READ_LATENCY - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic [31:0]          cnt;
  logic                 irq_q;
  logic [KEY_WIDTH-1:0] edge_q;
  logic                 rd_done;
  logic                 hold_done;

  logic [1:0]           address_d;
  logic                 chipselect_d;
  logic                 write_n_d;
  logic [31:0]          writedata_d;
  logic                 valid_d;

  // Upper readdata bits carry nothing for a KEY_WIDTH-bit PIO.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:KEY_WIDTH];

  assign rd_done   = (cnt == RD_LAST);
  assign hold_done = (cnt == HOLD_LAST);

  // Bus and stream outputs are registered, so they are decoded from the
  // next state. S_BOOT gives one cycle with reset-value outputs before the
  // S_INIT mask write is presented.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_BOOT;
      cnt            <= '0;
      irq_q          <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      event_valid    <= 1'b0;
      init_done      <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= (state_next == state) ? cnt + 32'd1 : '0;
      irq_q          <= irq;
      avm_address    <= address_d;
      avm_chipselect <= chipselect_d;
      avm_write_n    <= write_n_d;
      avm_writedata  <= writedata_d;
      event_valid    <= valid_d;
      if (state == S_INIT) begin
        init_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_INIT;
      S_INIT:  state_next = S_IDLE;
      S_IDLE:  if (irq_q) state_next = S_RD_EC;
      S_RD_EC: state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_done) begin
`ifdef AUDIO_FEED_KEY_LEVEL_READ_EN
          state_next = S_RD_LVL;
`else
          state_next = S_CLR;
`endif
        end
      end
`ifdef AUDIO_FEED_KEY_LEVEL_READ_EN
      S_RD_LVL:      state_next = S_RD_LVL_WAIT;
      S_RD_LVL_WAIT: if (rd_done) state_next = S_CLR;
`endif
      S_CLR:   state_next = (edge_q != '0) ? S_PUSH : S_IDLE;
      S_PUSH:  if (event_ready) state_next = S_HOLD;
      S_HOLD:  if (hold_done) state_next = S_IDLE;
      default: state_next = S_BOOT;
    endcase
  end

  always_comb begin
    address_d    = '0;
    chipselect_d = 1'b0;
    write_n_d    = 1'b1;
    writedata_d  = '0;
    valid_d      = 1'b0;
    case (state_next)
      S_INIT: begin
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        address_d    = 2'd2;
        writedata_d  = {28'b0, IRQ_MASK};
      end
      S_RD_EC: begin
        chipselect_d = 1'b1;
        address_d    = 2'd3;
      end
      S_RD_WAIT: address_d = 2'd3;
`ifdef AUDIO_FEED_KEY_LEVEL_READ_EN
      S_RD_LVL: begin
        chipselect_d = 1'b1;
        address_d    = 2'd0;
      end
      S_RD_LVL_WAIT: address_d = 2'd0;
`endif
      S_CLR: begin
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        address_d    = 2'd3;
        writedata_d  = '0;
      end
      S_PUSH:  valid_d = 1'b1;
      default: ;
    endcase
  end

  // Edge capture and event payload
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_q     <= '0;
      event_keys <= '0;
    end else begin
      if (state == S_RD_WAIT && rd_done) begin
        edge_q <= avm_readdata[KEY_WIDTH-1:0];
      end
      if (state == S_CLR && edge_q != '0) begin
        event_keys <= edge_q;
      end
    end
  end

`ifdef AUDIO_FEED_KEY_LEVEL_READ_EN
  logic [KEY_WIDTH-1:0] lvl_q;
  logic [KEY_WIDTH-1:0] level_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lvl_q   <= '0;
      level_r <= '0;
    end else begin
      if (state == S_RD_LVL_WAIT && rd_done) begin
        lvl_q <= avm_readdata[KEY_WIDTH-1:0];
      end
      if (state == S_CLR && edge_q != '0) begin
        level_r <= lvl_q;
      end
    end
  end

  assign event_level = level_r;
`else
  assign event_level = '0;
`endif

endmodule
